// File: rtl/fifo_in_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_in_writer_pkg
//  Purpose  : Shared register map and bit positions for the FIFO-in writer
//             Avalon-MM slave and its circular buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_in_writer_pkg;

  // Register word offsets on the 2-bit Avalon address
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_DROPS   = 2'd3;

  // STATUS bit positions
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_FIFO_FULL = 2;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_LEVEL_W   = 5;

  // CONTROL bit positions
  localparam int CTRL_FLUSH = 0;

endpackage
`default_nettype wire

// File: rtl/fifo_in_writer_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_in_writer_buf
//  Purpose  : Small circular buffer holding words pushed by the HPS until the
//             drain logic forwards them downstream.
//  Ports    : clk, reset        - clock, async active-high reset
//             push_i/push_data_i - store a word at the tail (caller ensures
//                                  the buffer is not full)
//             pop_i              - advance head (caller ensures non-empty)
//             flush_i            - empty the buffer; wins over push/pop
//             head_data_o        - word at the head
//             full_o, empty_o    - occupancy flags
//             level_o            - number of stored words, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_in_writer_buf
  import fifo_in_writer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic [DATA_WIDTH-1:0]         push_data_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  output logic [DATA_WIDTH-1:0]         head_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH):0]        level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] C_FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [LVL_W-1:0]      level_q, level_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + 1'b1;
      if (pop_i)  head_d = head_q + 1'b1;
      // Simultaneous push and pop leaves the level unchanged
      case ({push_i, pop_i})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: contents are only visible through level/head
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[tail_q] <= push_data_i;
  end

  assign head_data_o = mem_q[head_q];
  assign full_o      = (level_q == C_FULL_LVL);
  assign empty_o     = (level_q == '0);
  assign level_o     = level_q;

endmodule
`default_nettype wire

// File: rtl/fifo_in_writer_pio.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_in_writer_pio
//  Purpose  : Avalon-MM slave letting the HPS push 32-bit words into the
//             FPGA-side input FIFO through a local circular buffer, with
//             status, flush and a saturating dropped-write counter.
//  Ports    : clk, reset              - clock, async active-high reset
//             address/write/writedata - Avalon slave (zero wait states)
//             readdata                - registered read data (1-cycle latency)
//             fifo_full               - downstream almost-full flag
//             fifo_data/fifo_wrreq    - registered downstream write port
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_in_writer_pio
  import fifo_in_writer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_wrreq
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                  w_wr_data, w_wr_ctrl, w_wr_drops;
  logic                  w_push, w_pop, w_flush, w_drop;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_full, w_empty;
  logic [LVL_W-1:0]      w_level;
  logic [31:0]           w_status;

  logic [31:0]           readdata_q, readdata_d;
  logic                  wrreq_q, wrreq_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
  logic [31:0]           drops_q, drops_d;

  assign w_wr_data  = write && (address == ADDR_DATA);
  assign w_wr_ctrl  = write && (address == ADDR_CONTROL);
  assign w_wr_drops = write && (address == ADDR_DROPS);

  assign w_flush = w_wr_ctrl && writedata[CTRL_FLUSH];
  // Full is judged on pre-edge level, so a drain in the same cycle does not
  // rescue a push into a full buffer.
  assign w_push  = w_wr_data && !w_full;
  assign w_drop  = w_wr_data && w_full;
  assign w_pop   = !w_empty && !fifo_full && !w_flush;

  fifo_in_writer_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_push),
    .push_data_i (writedata[DATA_WIDTH-1:0]),
    .pop_i       (w_pop),
    .flush_i     (w_flush),
    .head_data_o (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .level_o     (w_level)
  );

  always_comb begin
    w_status                                  = '0;
    w_status[STAT_FULL]                       = w_full;
    w_status[STAT_EMPTY]                      = w_empty;
    w_status[STAT_FIFO_FULL]                  = fifo_full;
    w_status[STAT_LEVEL_LSB +: STAT_LEVEL_W]  = STAT_LEVEL_W'(w_level);
  end

  always_comb begin
    readdata_d = '0;
    wrreq_d    = w_pop;
    fdata_d    = w_pop ? w_head : fdata_q;
    drops_d    = drops_q;

    case (address)
      ADDR_STATUS: readdata_d = w_status;
      ADDR_DROPS:  readdata_d = drops_q;
      default:     readdata_d = '0;
    endcase

    if (w_wr_drops) begin
      drops_d = '0;
    end else if (w_drop && (drops_q != 32'hFFFF_FFFF)) begin
      drops_d = drops_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= '0;
      wrreq_q    <= 1'b0;
      fdata_q    <= '0;
      drops_q    <= '0;
    end else begin
      readdata_q <= readdata_d;
      wrreq_q    <= wrreq_d;
      fdata_q    <= fdata_d;
      drops_q    <= drops_d;
    end
  end

  assign readdata   = readdata_q;
  assign fifo_wrreq = wrreq_q;
  assign fifo_data  = fdata_q;

endmodule
`default_nettype wire
